// File: rtl/multu_hilo_if.sv
// Execute-stage multiply/HI-LO bundle: request, operands and result select in,
// selected result plus busy/done/stall status out.
interface multu_hilo_if #(
   parameter int WIDTH = 32
);
   logic             Multu;
   logic [1:0]       sel;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] alu_result;
   logic [WIDTH-1:0] result;
   logic             busy;
   logic             done;
   logic             stall;

   // Handshake: Multu is a level request sampled on each rising edge while the
   // unit is IDLE or DONE (ignored while BUSY); done is a one-cycle pulse meaning
   // HI/LO now hold the new product; stall asks the pipeline to hold mfhi/mflo.
   modport master (
      output Multu, sel, op_a, op_b, alu_result,
      input  result, busy, done, stall
   );

   modport slave (
      input  Multu, sel, op_a, op_b, alu_result,
      output result, busy, done, stall
   );
endinterface

// File: rtl/multu_hilo.sv
// Multi-cycle unsigned shift-add multiplier feeding architectural HI/LO, with
// EX-stage result select and stall request for premature mfhi/mflo.
module multu_hilo #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic         clk,
   input  logic         rst_n,
   multu_hilo_if.slave  bus,
   output logic [1:0]   dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     hi_q, lo_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [2*WIDTH-1:0]   mcand_q, acc_q;
   logic [WIDTH-1:0]     mplier_q;
   logic [2*WIDTH-1:0]   acc_sum;
   logic                 start, last;

   // Sum including this step's addend, so the final step commits a complete product.
   assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

   always_comb begin
      state_d = state_q;
      start   = 1'b0;
      last    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.Multu) begin
               start   = 1'b1;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q == LAST) begin
               last    = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.Multu) begin
               start   = 1'b1;
               state_d = BUSY;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_q     <= '0;
         lo_q     <= '0;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
      end else if (start) begin
         mcand_q  <= {{WIDTH{1'b0}}, bus.op_a};
         mplier_q <= bus.op_b;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else if (state_q == BUSY) begin
         acc_q    <= acc_sum;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q + 1'b1;
         if (last) begin
            hi_q <= acc_sum[2*WIDTH-1:WIDTH];
            lo_q <= acc_sum[WIDTH-1:0];
         end
      end
   end

   always_comb begin
      bus.result = '0;
      case (bus.sel)
         2'b00:   bus.result = bus.alu_result;
         2'b01:   bus.result = hi_q;
         2'b10:   bus.result = lo_q;
         default: bus.result = '0;
      endcase
   end

   assign bus.busy  = (state_q == BUSY);
   assign bus.done  = (state_q == DONE);
   assign bus.stall = bus.busy & ((bus.sel == 2'b01) | (bus.sel == 2'b10));
   assign dbg_state = state_q;

endmodule

// File: tb/tb_multu_hilo.sv
// Self-checking bench for multu_hilo: randomized multiplies checked against a
// plain-arithmetic product model, plus reset, stall, back-to-back and abort cases.
module tb_multu_hilo;

   logic        clk;
   logic        rst_n;
   logic [1:0]  dbg_state;
   int          pass_cnt;
   int          total_cnt;
   logic [31:0] m_hi, m_lo;
   logic [63:0] exp_q[$];
   logic [1:0]  idle_code;

   multu_hilo_if #(.WIDTH(32)) bus ();

   multu_hilo #(.WIDTH(32), .CNT_W(6)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Driven from the negedge: request a multiply and record its expected product.
   task automatic issue(input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      p = {32'h0, a} * {32'h0, b};
      bus.Multu = 1'b1;
      bus.op_a  = a;
      bus.op_b  = b;
      exp_q.push_back(p);
   endtask

   // Waits (bounded) for done; lat is negedges from issue to done, -1 on timeout.
   task automatic wait_done(output int lat, output int nbusy);
      logic [63:0] p;
      lat   = -1;
      nbusy = 0;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         bus.Multu = 1'b0;
         if (bus.busy === 1'b1) nbusy++;
         if (bus.done === 1'b1) begin
            lat = i;
            break;
         end
      end
      p = exp_q.pop_front();
      m_hi = p[63:32];
      m_lo = p[31:0];
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.Multu = 1'b0;
      bus.sel = 2'b01;
      bus.op_a = '0;
      bus.op_b = '0;
      bus.alu_result = 32'hdead_beef;
      m_hi = '0;
      m_lo = '0;
      repeat (2) @(negedge clk);
      total_cnt++;
      if (bus.result !== 32'h0) $display("FAIL reset_result: got %h expected %h", bus.result, 32'h0);
      else pass_cnt++;
      total_cnt++;
      if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy);
      else pass_cnt++;
      total_cnt++;
      if (bus.done !== 1'b0) $display("FAIL reset_done: got %b expected 0", bus.done);
      else pass_cnt++;
      total_cnt++;
      if (bus.stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", bus.stall);
      else pass_cnt++;
      idle_code = dbg_state;
      rst_n = 1'b1;
      bus.sel = 2'b00;
      bus.alu_result = 32'h1234;
      #1;
      total_cnt++;
      if (bus.result !== 32'h1234) $display("FAIL reset_passthru: got %h expected %h", bus.result, 32'h1234);
      else pass_cnt++;
   endtask

   task automatic test_basic();
      int lat, nbusy;
      @(negedge clk);
      issue(32'd7, 32'd6);
      @(posedge clk);
      #1;
      total_cnt++;
      if (dbg_state === idle_code) $display("FAIL basic_dbg_state: got %h, expected a code other than idle %h", dbg_state, idle_code);
      else pass_cnt++;
      @(negedge clk);
      bus.Multu = 1'b0;
      wait_done(lat, nbusy);
      lat = lat + 1;
      nbusy = nbusy + 1;
      total_cnt++;
      if (lat !== 33) $display("FAIL basic_latency: got %0d expected 33", lat);
      else pass_cnt++;
      total_cnt++;
      if (nbusy !== 32) $display("FAIL basic_busy_cycles: got %0d expected 32", nbusy);
      else pass_cnt++;
      bus.sel = 2'b10;
      #1;
      total_cnt++;
      if (bus.result !== m_lo || m_lo !== 32'd42) $display("FAIL basic_lo: got %h expected %h", bus.result, 32'd42);
      else pass_cnt++;
      bus.sel = 2'b01;
      #1;
      total_cnt++;
      if (bus.result !== m_hi) $display("FAIL basic_hi: got %h expected %h", bus.result, m_hi);
      else pass_cnt++;
   endtask

   task automatic test_stall();
      int lat, nbusy;
      logic [31:0] old_hi;
      old_hi = m_hi;
      @(negedge clk);
      issue(32'h0001_0000, 32'h0001_0000);
      @(negedge clk);
      bus.Multu = 1'b0;
      bus.sel = 2'b01;
      #1;
      total_cnt++;
      if (bus.stall !== 1'b1) $display("FAIL stall_busy: got %b expected 1", bus.stall);
      else pass_cnt++;
      total_cnt++;
      if (bus.result !== old_hi) $display("FAIL stall_stale_hi: got %h expected %h", bus.result, old_hi);
      else pass_cnt++;
      wait_done(lat, nbusy);
      total_cnt++;
      if (lat < 0 || bus.stall !== 1'b0) $display("FAIL stall_done: got stall=%b lat=%0d expected stall=0", bus.stall, lat);
      else pass_cnt++;
      total_cnt++;
      if (bus.result !== 32'h1) $display("FAIL stall_new_hi: got %h expected %h", bus.result, 32'h1);
      else pass_cnt++;
      bus.sel = 2'b10;
      #1;
      total_cnt++;
      if (bus.result !== m_lo) $display("FAIL stall_new_lo: got %h expected %h", bus.result, m_lo);
      else pass_cnt++;
   endtask

   // Random and corner operands; mid-busy reads check stall and stale HI/LO.
   task automatic test_products();
      int lat, nbusy;
      logic [31:0] a, b, exp_r;
      logic [1:0] s;
      for (int n = 0; n < 10; n++) begin
         case (n)
            0: begin a = 32'hffff_ffff; b = 32'hffff_ffff; end
            1: begin a = 32'h8000_0000; b = 32'd2; end
            2: begin a = 32'h0; b = $urandom; end
            default: begin a = $urandom; b = $urandom; end
         endcase
         @(negedge clk);
         issue(a, b);
         repeat ($urandom_range(2, 20)) @(negedge clk);
         bus.Multu = 1'b0;
         s = 2'($urandom_range(0, 3));
         bus.sel = s;
         bus.alu_result = $urandom;
         #1;
         exp_r = (s == 2'b00) ? bus.alu_result : (s == 2'b01) ? m_hi : (s == 2'b10) ? m_lo : 32'h0;
         total_cnt++;
         if (bus.result !== exp_r || bus.stall !== (s == 2'b01 || s == 2'b10))
            $display("FAIL prod_midbusy[%0d]: got result=%h stall=%b expected result=%h sel=%0d", n, bus.result, bus.stall, exp_r, s);
         else pass_cnt++;
         wait_done(lat, nbusy);
         bus.sel = 2'b01;
         #1;
         total_cnt++;
         if (lat < 0 || bus.result !== m_hi) $display("FAIL prod_hi[%0d]: got %h expected %h (lat %0d)", n, bus.result, m_hi, lat);
         else pass_cnt++;
         bus.sel = 2'b10;
         #1;
         total_cnt++;
         if (bus.result !== m_lo) $display("FAIL prod_lo[%0d]: got %h expected %h", n, bus.result, m_lo);
         else pass_cnt++;
      end
   endtask

   task automatic test_back_to_back();
      int lat, nbusy;
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      @(negedge clk);
      issue(a, b);
      repeat (5) @(negedge clk);
      bus.Multu = 1'b1;
      bus.op_a = ~a;
      bus.op_b = b ^ 32'h5a5a_5a5a;
      @(negedge clk);
      bus.Multu = 1'b0;
      wait_done(lat, nbusy);
      bus.sel = 2'b10;
      #1;
      total_cnt++;
      if (lat < 0 || bus.result !== m_lo) $display("FAIL ignore_lo: got %h expected %h", bus.result, m_lo);
      else pass_cnt++;
      bus.sel = 2'b01;
      #1;
      total_cnt++;
      if (bus.result !== m_hi) $display("FAIL ignore_hi: got %h expected %h", bus.result, m_hi);
      else pass_cnt++;
      issue(32'd3, 32'd5);
      wait_done(lat, nbusy);
      total_cnt++;
      if (lat !== 33) $display("FAIL b2b_latency: got %0d expected 33", lat);
      else pass_cnt++;
      bus.sel = 2'b10;
      #1;
      total_cnt++;
      if (bus.result !== 32'd15) $display("FAIL b2b_lo: got %h expected %h", bus.result, 32'd15);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      int lat, nbusy;
      logic [63:0] dropped;
      @(negedge clk);
      issue(32'h0000_ffff, 32'h0000_ffff);
      repeat (11) @(negedge clk);
      bus.Multu = 1'b0;
      rst_n = 1'b0;
      dropped = exp_q.pop_front();
      m_hi = '0;
      m_lo = '0;
      bus.sel = 2'b01;
      #1;
      total_cnt++;
      if (bus.busy !== 1'b0 || bus.stall !== 1'b0 || bus.result !== 32'h0)
         $display("FAIL abort_hi: got busy=%b stall=%b hi=%h expected 0/0/0 (dropped %h)", bus.busy, bus.stall, bus.result, dropped);
      else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      bus.sel = 2'b10;
      #1;
      total_cnt++;
      if (bus.result !== 32'h0 || dbg_state !== idle_code) $display("FAIL abort_lo: got lo=%h state=%h expected 0 idle", bus.result, dbg_state);
      else pass_cnt++;
      @(negedge clk);
      issue(32'd2, 32'd3);
      wait_done(lat, nbusy);
      total_cnt++;
      if (lat !== 33 || bus.result !== 32'd6) $display("FAIL abort_recover: got lo=%h lat=%0d expected 6 lat 33", bus.result, lat);
      else pass_cnt++;
      bus.sel = 2'b01;
      #1;
      total_cnt++;
      if (bus.result !== 32'h0) $display("FAIL abort_recover_hi: got %h expected 0", bus.result);
      else pass_cnt++;
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      test_reset();
      test_basic();
      test_stall();
      test_products();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/multu_hilo.md
Name: multu_hilo

Overview:
- Execute-stage consumer of the ALU control decode outputs `Multu` and `sel`.
- Performs a multi-cycle unsigned 32x32 multiply by radix-2 shift-add and holds the 64-bit product in architectural HI/LO registers.
- Selects the EX-stage result: the ALU result, HI (mfhi) or LO (mflo).
- Issues a stall request when mfhi/mflo would read HI/LO before an in-flight multiply completes.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; product is 2*WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- Multu  input  1  multiply request from ALU control decode; level, sampled each rising edge.
- sel  input  2  result select: 00 = ALU result, 01 = HI, 10 = LO, 11 = reserved.
- op_a  input  WIDTH  multiplicand (rs value).
- op_b  input  WIDTH  multiplier (rt value).
- alu_result  input  WIDTH  ALU output, passed through when sel=00.
- result  output  WIDTH  selected EX-stage result.
- busy  output  1  multiply in progress.
- done  output  1  single-cycle pulse; HI/LO hold the new product.
- stall  output  1  pipeline hold request.

Behaviour:
Reset:
- Clock and reset: one clock `clk`. Reset `rst_n` is asynchronous and active-low.
- While rst_n=0: state=IDLE, HI=0, LO=0, counter=0, internal multiplicand/multiplier/accumulator=0, busy=0, done=0.
- Outputs derived from that state: stall=0; result=alu_result for sel=00, otherwise 0.
- Reset asserted mid-multiply aborts it; no partial product ever reaches HI/LO.

State machine: IDLE, BUSY, DONE.
- IDLE, Multu=1 at edge E0:
  - latch mcand={WIDTH'b0, op_a}, mplier=op_b, acc=0, counter=0; go to BUSY.
- BUSY, each edge:
  - if mplier[0], acc = acc + mcand (2*WIDTH-bit add, no overflow possible);
  - mcand <<= 1; mplier >>= 1; counter += 1.
  - On the edge where counter==WIDTH-1 (edge E_WIDTH), write HI=final acc[2*WIDTH-1:WIDTH] and LO=final acc[WIDTH-1:0] atomically, including that step's addend; go to DONE.
- DONE, one cycle with done=1:
  - Multu=1 starts a new multiply exactly as from IDLE (back-to-back issue); otherwise go to IDLE.
- Multu while in BUSY: ignored; op_a/op_b changes during BUSY have no effect.

Timing and outputs:
- busy=1 exactly for cycles E0..E_WIDTH (WIDTH cycles).
- done=1 for the single cycle after E_WIDTH; busy=0 in DONE.
- HI/LO change only at E_WIDTH. During BUSY they keep the previous product.
- result (combinational):
  - sel=00 -> alu_result
  - sel=01 -> HI
  - sel=10 -> LO
  - sel=11 -> 0
- stall = busy & (sel==01 | sel==10). Combinational; no stall for sel=00 or 11.
- In the DONE cycle, stall=0 and result returns the new HI/LO (read-after-write visible with no bubble).
- Width rules: operands unsigned, zero-extended. Product = op_a*op_b mod 2**(2*WIDTH), exact for all inputs.

Test Plan:
- Reset:
  - Drive rst_n=0, sel=01 -> result=0, busy=0, done=0, stall=0.
  - Release, set sel=00, alu_result=0x1234 -> result=0x1234.
- Basic multiply:
  - Multu=1 one cycle, op_a=7, op_b=6 -> busy high for 32 cycles, done pulses on cycle 33.
  - Then sel=10 -> result=42; sel=01 -> result=0.
- Max operands:
  - op_a=op_b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
  - op_a=0x80000000, op_b=2 -> HI=1, LO=0.
- Stall and stale read:
  - After the 7*6 product, start 0x10000*0x10000.
  - sel=01 during BUSY -> stall=1, result=0 (old HI).
  - In the DONE cycle -> stall=0, HI=1, LO=0.
- Ignore and back-to-back:
  - Toggle Multu and op_a mid-BUSY -> final product unchanged.
  - Multu=1 in the DONE cycle with 3*5 -> second done exactly 33 cycles later, LO=15.
- Reset mid-operation:
  - Assert rst_n=0 at iteration 10 of 0xFFFF*0xFFFF -> HI=LO=0, state IDLE.
  - New 2*3 request after release completes normally, LO=6.
